// File: rtl/ysyx_22041412_pkg.sv
// Shared writeback definitions: data width, register count and the
// slow-path holding entry layout.
package ysyx_22041412_pkg;

    localparam int unsigned XLEN    = 64;
    localparam int unsigned REG_NUM = 32;
    localparam int unsigned RW      = $clog2(REG_NUM);

    // One pending register-file write waiting in the slow-path FIFO.
    typedef struct packed {
        logic [RW-1:0]   rd;
        logic [XLEN-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/ysyx_22041412_wb_fifo.sv
// Slow-path (LSU/MDU) holding FIFO for the writeback unit.
// Ports:
//   clk, rst       - clock, asynchronous active-low reset
//   push, push_entry - write one entry (ignored while full)
//   pop            - consume the head entry (ignored while empty)
//   full, empty    - occupancy flags derived from the registered count
//   head           - entry at the read pointer
module ysyx_22041412_wb_fifo
    import ysyx_22041412_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_entry,
    input  logic      pop,
    output logic      full,
    output logic      empty,
    output wb_entry_t head
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    wb_entry_t       mem [DEPTH];
    logic [AW-1:0]   rd_ptr;
    logic [AW-1:0]   wr_ptr;
    logic [CW-1:0]   count;
    logic            do_push;
    logic            do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset; validity is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_entry;
    end

endmodule

// File: rtl/ysyx_22041412_wbu.sv
// Writeback unit: merges the single-cycle ALU result and the buffered
// LSU/MDU result into one registered register-file write port, and keeps
// the pending-write scoreboard used by the issue stage.
// Ports:
//   clk, rst                      - clock, asynchronous active-low reset
//   issue_valid, issue_rd, issue_ok - issue request and hazard-free indication
//   ex_valid, ex_rd, ex_data      - ALU result, always accepted, highest priority
//   ls_valid, ls_rd, ls_data, ls_ready - slow-path result handshake into FIFO
//   rf_wen, rf_rw, rf_busw        - registered register-file write port
//   busy                          - per-register outstanding-write scoreboard
module ysyx_22041412_wbu
    import ysyx_22041412_pkg::wb_entry_t;
#(
    parameter int unsigned XLEN     = 64,
    parameter int unsigned LS_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            issue_valid,
    input  logic [4:0]      issue_rd,
    output logic            issue_ok,
    input  logic            ex_valid,
    input  logic [4:0]      ex_rd,
    input  logic [XLEN-1:0] ex_data,
    input  logic            ls_valid,
    input  logic [4:0]      ls_rd,
    input  logic [XLEN-1:0] ls_data,
    output logic            ls_ready,
    output logic            rf_wen,
    output logic [4:0]      rf_rw,
    output logic [XLEN-1:0] rf_busw,
    output logic [31:0]     busy
);

    localparam int unsigned EW      = ysyx_22041412_pkg::XLEN;
    localparam int unsigned REG_NUM = ysyx_22041412_pkg::REG_NUM;

    wb_entry_t          push_entry;
    wb_entry_t          head;
    logic               fifo_full;
    logic               fifo_empty;
    logic               ls_push;
    logic               fifo_pop;

    logic               sel_valid;
    logic [4:0]         sel_rd;
    logic [XLEN-1:0]    sel_data;

    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;
    logic [REG_NUM-1:0] busy_next;

    // Slow-path handshake; ready comes from registered occupancy only.
    assign ls_ready        = !fifo_full;
    assign ls_push         = ls_valid && ls_ready;
    assign fifo_pop        = !ex_valid && !fifo_empty;
    assign push_entry.rd   = ls_rd;
    assign push_entry.data = EW'(ls_data);

    ysyx_22041412_wb_fifo #(
        .DEPTH (LS_DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (ls_push),
        .push_entry (push_entry),
        .pop        (fifo_pop),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .head       (head)
    );

    // Source select: ALU first, then FIFO head.
    always_comb begin
        sel_valid = 1'b0;
        sel_rd    = '0;
        sel_data  = '0;
        if (ex_valid) begin
            sel_valid = 1'b1;
            sel_rd    = ex_rd;
            sel_data  = ex_data;
        end else if (!fifo_empty) begin
            sel_valid = 1'b1;
            sel_rd    = head.rd;
            sel_data  = XLEN'(head.data);
        end
    end

    // Register-file write port; x0 entries are consumed but never written.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rf_wen  <= 1'b0;
            rf_rw   <= '0;
            rf_busw <= '0;
        end else begin
            rf_wen <= sel_valid && (sel_rd != 5'd0);
            if (sel_valid) begin
                rf_rw   <= sel_rd;
                rf_busw <= sel_data;
            end
        end
    end

    // Scoreboard: a new issue overrides a retiring write to the same register.
    assign issue_ok = (issue_rd == 5'd0) || !busy[issue_rd];

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (issue_valid && issue_ok && (issue_rd != 5'd0))
            set_vec = REG_NUM'(1) << issue_rd;
        if (rf_wen)
            clr_vec = REG_NUM'(1) << rf_rw;
        busy_next = ((busy & ~clr_vec) | set_vec) & ~REG_NUM'(1);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) busy <= '0;
        else      busy <= busy_next;
    end

endmodule

// File: tb/tb_ysyx_22041412_wbu.sv
// Directed bench for the writeback unit.
module tb_ysyx_22041412_wbu;

    logic        clk;
    logic        rst;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        issue_ok;
    logic        ex_valid;
    logic [4:0]  ex_rd;
    logic [63:0] ex_data;
    logic        ls_valid;
    logic [4:0]  ls_rd;
    logic [63:0] ls_data;
    logic        ls_ready;
    logic        rf_wen;
    logic [4:0]  rf_rw;
    logic [63:0] rf_busw;
    logic [31:0] busy;

    int checks;
    int errors;

    ysyx_22041412_wbu #(.XLEN(64), .LS_DEPTH(2)) dut (
        .clk         (clk),
        .rst         (rst),
        .issue_valid (issue_valid),
        .issue_rd    (issue_rd),
        .issue_ok    (issue_ok),
        .ex_valid    (ex_valid),
        .ex_rd       (ex_rd),
        .ex_data     (ex_data),
        .ls_valid    (ls_valid),
        .ls_rd       (ls_rd),
        .ls_data     (ls_data),
        .ls_ready    (ls_ready),
        .rf_wen      (rf_wen),
        .rf_rw       (rf_rw),
        .rf_busw     (rf_busw),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        exv;
        logic [4:0]  exrd;
        logic [63:0] exd;
        logic        lsv;
        logic [4:0]  lsrd;
        logic [63:0] lsd;
        logic        iv;
        logic [4:0]  ird;
        logic        e_ready;
        logic        e_iok;
        logic        e_wen;
        logic [4:0]  e_rw;
        logic [63:0] e_busw;
        logic [31:0] e_busy;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add(input logic exv, input logic [4:0] exrd, input logic [63:0] exd,
                       input logic lsv, input logic [4:0] lsrd, input logic [63:0] lsd,
                       input logic iv, input logic [4:0] ird,
                       input logic e_ready, input logic e_iok,
                       input logic e_wen, input logic [4:0] e_rw, input logic [63:0] e_busw,
                       input logic [31:0] e_busy);
        vec_t v;
        v.exv = exv; v.exrd = exrd; v.exd = exd;
        v.lsv = lsv; v.lsrd = lsrd; v.lsd = lsd;
        v.iv = iv; v.ird = ird;
        v.e_ready = e_ready; v.e_iok = e_iok;
        v.e_wen = e_wen; v.e_rw = e_rw; v.e_busw = e_busw; v.e_busy = e_busy;
        vecs.push_back(v);
    endtask

    task automatic drive_idle();
        ex_valid = 0; ex_rd = 0; ex_data = 0;
        ls_valid = 0; ls_rd = 0; ls_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        drive_idle();

        //  exv rd  data        lsv rd  data       iv rd | rdy iok wen rw  busw       busy
        add(1, 5, 64'h1234,     0, 0,  64'h0,     0, 0,    1,  1,  1,  5,  64'h1234,  32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h0);
        // ALU keeps the port busy while two slow results fill the FIFO
        add(1, 1, 64'h11,       1, 7,  64'hAA,    0, 0,    1,  1,  1,  1,  64'h11,    32'h0);
        add(1, 2, 64'h22,       1, 8,  64'hBB,    0, 0,    1,  1,  1,  2,  64'h22,    32'h0);
        add(1, 4, 64'h44,       1, 9,  64'hCC,    0, 0,    0,  1,  1,  4,  64'h44,    32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    0,  1,  1,  7,  64'hAA,    32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  1,  8,  64'hBB,    32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h0);
        // write to x0 is suppressed
        add(1, 0, 64'hFFFF,     0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h0);
        // scoreboard set by issue, cleared after slow write to x10
        add(0, 0, 64'h0,        0, 0,  64'h0,     1, 10,   1,  1,  0,  0,  64'h0,     32'h400);
        add(0, 0, 64'h0,        1, 10, 64'h55,    0, 10,   1,  0,  0,  0,  64'h0,     32'h400);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 10,   1,  0,  1,  10, 64'h55,    32'h400);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 10,   1,  0,  0,  0,  64'h0,     32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 10,   1,  1,  0,  0,  64'h0,     32'h0);
        // issue on the retire cycle of the same register: set wins
        add(1, 3, 64'h33,       0, 0,  64'h0,     0, 0,    1,  1,  1,  3,  64'h33,    32'h0);
        add(0, 0, 64'h0,        0, 0,  64'h0,     1, 3,    1,  1,  0,  0,  64'h0,     32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 3,    1,  0,  0,  0,  64'h0,     32'h8);
        // concurrent push and pop keeps one entry in flight
        add(0, 0, 64'h0,        1, 11, 64'h77,    0, 0,    1,  1,  0,  0,  64'h0,     32'h8);
        add(0, 0, 64'h0,        1, 12, 64'h88,    0, 0,    1,  1,  1,  11, 64'h77,    32'h8);
        add(0, 0, 64'h0,        1, 13, 64'h99,    0, 0,    1,  1,  1,  12, 64'h88,    32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  1,  13, 64'h99,    32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h8);
        // slow-path entry for x0 is consumed silently
        add(0, 0, 64'h0,        1, 0,  64'hDEAD,  0, 0,    1,  1,  0,  0,  64'h0,     32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     0, 0,    1,  1,  0,  0,  64'h0,     32'h8);
        // build busy=0x480 with two entries parked in the FIFO
        add(1, 3, 64'h3,        0, 0,  64'h0,     0, 0,    1,  1,  1,  3,  64'h3,     32'h8);
        add(0, 0, 64'h0,        0, 0,  64'h0,     1, 7,    1,  1,  0,  0,  64'h0,     32'h80);
        add(1, 1, 64'h1,        1, 20, 64'hA0,    1, 10,   1,  1,  1,  1,  64'h1,     32'h480);
        add(1, 2, 64'h2,        1, 21, 64'hA1,    0, 0,    1,  1,  1,  2,  64'h2,     32'h480);

        repeat (2) @(posedge clk);
        #1;
        check("reset_wen",   64'(rf_wen),   64'(0));
        check("reset_rw",    64'(rf_rw),    64'(0));
        check("reset_busw",  rf_busw,       64'(0));
        check("reset_busy",  64'(busy),     64'(0));
        check("reset_ready", 64'(ls_ready), 64'(1));
        rst = 1'b1;

        for (int i = 0; i < vecs.size(); i++) begin
            ex_valid = vecs[i].exv; ex_rd = vecs[i].exrd; ex_data = vecs[i].exd;
            ls_valid = vecs[i].lsv; ls_rd = vecs[i].lsrd; ls_data = vecs[i].lsd;
            issue_valid = vecs[i].iv; issue_rd = vecs[i].ird;
            #3;
            check($sformatf("v%0d_ls_ready", i), 64'(ls_ready), 64'(vecs[i].e_ready));
            check($sformatf("v%0d_issue_ok", i), 64'(issue_ok), 64'(vecs[i].e_iok));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_rf_wen", i), 64'(rf_wen), 64'(vecs[i].e_wen));
            if (vecs[i].e_wen) begin
                check($sformatf("v%0d_rf_rw", i),   64'(rf_rw), 64'(vecs[i].e_rw));
                check($sformatf("v%0d_rf_busw", i), rf_busw,    vecs[i].e_busw);
            end
            check($sformatf("v%0d_busy", i), 64'(busy), 64'(vecs[i].e_busy));
        end

        // Asynchronous reset mid-operation: two FIFO entries, busy=0x480, rf_wen high.
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        check("async_wen",   64'(rf_wen),   64'(0));
        check("async_rw",    64'(rf_rw),    64'(0));
        check("async_busw",  rf_busw,       64'(0));
        check("async_busy",  64'(busy),     64'(0));
        check("async_ready", 64'(ls_ready), 64'(1));
        @(posedge clk);
        #1;
        check("held_wen", 64'(rf_wen), 64'(0));
        #2;
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check($sformatf("post_rst%0d_wen", c),   64'(rf_wen),   64'(0));
            check($sformatf("post_rst%0d_busy", c),  64'(busy),     64'(0));
            check($sformatf("post_rst%0d_ready", c), 64'(ls_ready), 64'(1));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
